// File: rtl/text_pixel_gen.sv
// Text-mode pixel generator: cell address -> character code -> font row -> pixel bit.
// The four register stages put pixel, active_out and the syncs 3 edges after the
// inputs are sampled. A blinking inverse cursor is overlaid on one cell.
module text_pixel_gen #(
  parameter int COLS       = 80,
  parameter int ROWS       = 60,
  parameter int CELL_AW    = 13,
  parameter int GLYPH_BITS = 4,
  parameter int BLINK_LOG2 = 5
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [9:0]              hpos,
  input  logic [9:0]              vpos,
  input  logic                    active_in,
  input  logic                    hsync_in,
  input  logic                    vsync_in,
  input  logic                    cursor_en,
  input  logic [6:0]              cursor_col,
  input  logic [5:0]              cursor_row,
  output logic [CELL_AW-1:0]      char_addr,
  input  logic [7:0]              char_data,
  output logic [GLYPH_BITS+2:0]   font_addr,
  input  logic [7:0]              font_data,
  output logic                    pixel,
  output logic                    active_out,
  output logic                    hsync_out,
  output logic                    vsync_out
);

  localparam int FA_W = GLYPH_BITS + 3;
  localparam logic [7:0] COLS_L = 8'(COLS);
  localparam logic [7:0] ROWS_L = 8'(ROWS);

  // row*COLS + col built only from shifted copies of row (constant shift-add)
  function automatic logic [CELL_AW-1:0] cell_index(input logic [6:0] row,
                                                    input logic [6:0] col);
    logic [CELL_AW+7:0] acc;
    acc = '0;
    for (int i = 0; i < 31; i++) begin
      if (((COLS >> i) & 1) != 0)
        acc = acc + ({{(CELL_AW+1){1'b0}}, row} << i);
    end
    acc = acc + {{(CELL_AW+1){1'b0}}, col};
    return acc[CELL_AW-1:0];
  endfunction

  logic [6:0] hcell, vcell;
  assign hcell = hpos[9:3];
  assign vcell = vpos[9:3];

  // upper character-code bits select attributes elsewhere; not used here
  logic unused_char_bits;
  assign unused_char_bits = ^char_data[7:GLYPH_BITS];

  // stage 0 registers
  logic [CELL_AW-1:0] char_addr_q, char_addr_d;
  logic [2:0]         hsub_p0_q, vsub_p0_q;
  logic               act_p0_q, hs_p0_q, vs_p0_q, hit_p0_q, hit_p0_d;
  // stage 1 registers
  logic [FA_W-1:0]    font_addr_q, font_addr_d;
  logic [2:0]         hsub_p1_q;
  logic               act_p1_q, hs_p1_q, vs_p1_q, hit_p1_q;
  // stage 2 registers
  logic               bit_p2_q, bit_p2_d;
  logic               act_p2_q, hs_p2_q, vs_p2_q, hit_p2_q;
  // output registers
  logic               pixel_q, pixel_d, active_q, hsync_q, vsync_q;
  // frame counter for cursor blink
  logic [BLINK_LOG2-1:0] frame_cnt_q, frame_cnt_d;
  logic                  vs_prev_q, vs_fall, blink_phase;

  // Next-state for all stages: address/cursor match, font address, pixel select
  always_comb begin
    char_addr_d = '0;
    if (active_in)
      char_addr_d = cell_index(vcell, hcell);
    hit_p0_d = cursor_en && (hcell == cursor_col) && (vcell == {1'b0, cursor_row}) &&
               ({1'b0, cursor_col} < COLS_L) && ({2'b00, cursor_row} < ROWS_L);
    font_addr_d = {char_data[GLYPH_BITS-1:0], vsub_p0_q};
    bit_p2_d    = font_data[3'd7 - hsub_p1_q];
    vs_fall     = vs_prev_q & ~vsync_in;
    frame_cnt_d = frame_cnt_q + BLINK_LOG2'(vs_fall);
    blink_phase = frame_cnt_q[BLINK_LOG2-1];
    pixel_d     = act_p2_q & (bit_p2_q ^ (hit_p2_q & blink_phase));
  end

  // Pipeline and frame-counter registers; reset clears every stage
  always_ff @(posedge clk) begin
    if (reset) begin
      char_addr_q <= '0;
      hsub_p0_q   <= '0;
      vsub_p0_q   <= '0;
      act_p0_q    <= 1'b0;
      hs_p0_q     <= 1'b1;
      vs_p0_q     <= 1'b1;
      hit_p0_q    <= 1'b0;
      font_addr_q <= '0;
      hsub_p1_q   <= '0;
      act_p1_q    <= 1'b0;
      hs_p1_q     <= 1'b1;
      vs_p1_q     <= 1'b1;
      hit_p1_q    <= 1'b0;
      bit_p2_q    <= 1'b0;
      act_p2_q    <= 1'b0;
      hs_p2_q     <= 1'b1;
      vs_p2_q     <= 1'b1;
      hit_p2_q    <= 1'b0;
      pixel_q     <= 1'b0;
      active_q    <= 1'b0;
      hsync_q     <= 1'b1;
      vsync_q     <= 1'b1;
      frame_cnt_q <= '0;
      vs_prev_q   <= 1'b1;
    end else begin
      // stage 0: cell address and cursor match from the raw coordinates
      char_addr_q <= char_addr_d;
      hsub_p0_q   <= hpos[2:0];
      vsub_p0_q   <= vpos[2:0];
      act_p0_q    <= active_in;
      hs_p0_q     <= hsync_in;
      vs_p0_q     <= vsync_in;
      hit_p0_q    <= hit_p0_d;
      // stage 1: character code arrives, form the font address
      font_addr_q <= font_addr_d;
      hsub_p1_q   <= hsub_p0_q;
      act_p1_q    <= act_p0_q;
      hs_p1_q     <= hs_p0_q;
      vs_p1_q     <= vs_p0_q;
      hit_p1_q    <= hit_p0_q;
      // stage 2: font row arrives, pick the pixel bit (bit 7 is leftmost)
      bit_p2_q    <= bit_p2_d;
      act_p2_q    <= act_p1_q;
      hs_p2_q     <= hs_p1_q;
      vs_p2_q     <= vs_p1_q;
      hit_p2_q    <= hit_p1_q;
      // stage 3: blank outside the active area, apply cursor inversion
      pixel_q     <= pixel_d;
      active_q    <= act_p2_q;
      hsync_q     <= hs_p2_q;
      vsync_q     <= vs_p2_q;
      frame_cnt_q <= frame_cnt_d;
      vs_prev_q   <= vsync_in;
    end
  end

  assign char_addr  = char_addr_q;
  assign font_addr  = font_addr_q;
  assign pixel      = pixel_q;
  assign active_out = active_q;
  assign hsync_out  = hsync_q;
  assign vsync_out  = vsync_q;

endmodule

// File: tb/tb_text_pixel_gen.sv
// Bench for text_pixel_gen: memories modelled as arrays, outputs predicted from
// the sample taken 3 edges earlier, plus directed literal checks.
module tb_text_pixel_gen;

  localparam int COLS = 80;
  localparam int ROWS = 60;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  hpos, vpos;
  logic        active_in, hsync_in, vsync_in, cursor_en;
  logic [6:0]  cursor_col;
  logic [5:0]  cursor_row;
  logic [12:0] char_addr;
  logic [7:0]  char_data;
  logic [6:0]  font_addr;
  logic [7:0]  font_data;
  logic        pixel, active_out, hsync_out, vsync_out;

  logic [7:0] tmem [0:8191];
  logic [7:0] fmem [0:127];

  always #5 clk = ~clk;

  assign char_data = tmem[char_addr];
  assign font_data = fmem[font_addr];

  text_pixel_gen dut (
    .clk(clk), .reset(reset), .hpos(hpos), .vpos(vpos), .active_in(active_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .cursor_en(cursor_en),
    .cursor_col(cursor_col), .cursor_row(cursor_row), .char_addr(char_addr),
    .char_data(char_data), .font_addr(font_addr), .font_data(font_data),
    .pixel(pixel), .active_out(active_out), .hsync_out(hsync_out), .vsync_out(vsync_out)
  );

  int vec  = 0;
  int miss = 0;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
    vec++;
    if (got !== want) begin
      miss++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, got, want, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    bit rst; bit act; bit hs; bit vs; bit hit; bit pbit;
    int addr; int v; int h;
  } ent_t;

  ent_t hist [4];
  int   cnt;
  bit   prevvs;
  bit   chk_en;
  int   e_caddr, e_faddr;
  bit   e_pix, e_act, e_hs, e_vs;

  function automatic ent_t cleared();
    ent_t c;
    c.rst = 1; c.act = 0; c.hs = 1; c.vs = 1; c.hit = 0; c.pbit = 0;
    c.addr = 0; c.v = 0; c.h = 0;
    return c;
  endfunction

  initial begin : model
    ent_t n;
    bit ph;
    bit anyrst;
    int hp, vp, g;
    for (int i = 0; i < 4; i++) hist[i] = cleared();
    cnt = 0; prevvs = 1; chk_en = 0;
    e_caddr = 0; e_faddr = 0; e_pix = 0; e_act = 0; e_hs = 1; e_vs = 1;
    forever begin
      @(posedge clk);
      ph = ((cnt >> 4) & 1) != 0;
      if (reset) begin
        n = cleared();
      end else begin
        hp = int'(hpos); vp = int'(vpos);
        n.rst  = 0;
        n.act  = active_in;
        n.hs   = hsync_in;
        n.vs   = vsync_in;
        n.h    = hp % 8;
        n.v    = vp % 8;
        n.addr = active_in ? ((vp / 8) * COLS + hp / 8) % 8192 : 0;
        n.hit  = cursor_en && (int'(cursor_col) < COLS) && (int'(cursor_row) < ROWS) &&
                 (hp / 8 == int'(cursor_col)) && (vp / 8 == int'(cursor_row));
        g      = int'(tmem[n.addr]) % 16;
        n.pbit = fmem[g * 8 + n.v][7 - n.h];
      end
      hist[3] = hist[2]; hist[2] = hist[1]; hist[1] = hist[0]; hist[0] = n;
      if (reset) begin
        cnt = 0; prevvs = 1;
      end else begin
        if (prevvs && !vsync_in) cnt = (cnt + 1) % 32;
        prevvs = vsync_in;
      end
      e_caddr = hist[0].addr;
      e_faddr = hist[0].rst ? 0 : (int'(tmem[hist[1].addr]) % 16) * 8 + hist[1].v;
      anyrst  = hist[0].rst | hist[1].rst | hist[2].rst | hist[3].rst;
      if (anyrst) begin
        e_pix = 0; e_act = 0; e_hs = 1; e_vs = 1;
      end else begin
        e_act = hist[3].act; e_hs = hist[3].hs; e_vs = hist[3].vs;
        e_pix = hist[3].act & (hist[3].pbit ^ (hist[3].hit & ph));
      end
      if (reset) chk_en = 1;
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin : compare
    forever begin
      @(negedge clk);
      if (chk_en) begin
        check("char_addr",  32'(char_addr),  32'(e_caddr));
        check("font_addr",  32'(font_addr),  32'(e_faddr));
        check("pixel",      32'(pixel),      32'(e_pix));
        check("active_out", 32'(active_out), 32'(e_act));
        check("hsync_out",  32'(hsync_out),  32'(e_hs));
        check("vsync_out",  32'(vsync_out),  32'(e_vs));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic draw_cell(input bit inv);
    for (int i = 0; i < 11; i++) begin
      hpos = (i < 8) ? 10'(i) : 10'd700;
      vpos = 10'd0;
      active_in = (i < 8);
      @(negedge clk);
      if (i >= 3) check("cursor_px", 32'(pixel), 32'(inv));
    end
  endtask

  task automatic pulse_vsync();
    vsync_in = 1'b0;
    @(negedge clk);
    vsync_in = 1'b1;
    @(negedge clk);
  endtask

  initial begin : stim
    logic [7:0] pat;
    for (int i = 0; i < 8192; i++) tmem[i] = 8'($urandom);
    for (int i = 0; i < 128; i++)  fmem[i] = 8'($urandom);
    tmem[82] = 8'h35;
    fmem[7'h29] = 8'hA0;
    tmem[0] = 8'h00;
    fmem[0] = 8'h00;
    for (int i = 1; i < 8; i++) fmem[i] = 8'hFF;

    // reset for 2 cycles with a visible, hsync-low input held throughout
    reset = 1; hpos = 10'd16; vpos = 10'd9; active_in = 1; hsync_in = 0; vsync_in = 1;
    cursor_en = 0; cursor_col = 7'd0; cursor_row = 6'd0;
    @(negedge clk);
    @(negedge clk);
    reset = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("rst_active", 32'(active_out), 32'(k == 3));
      check("rst_hsync",  32'(hsync_out),  32'(k != 3));
      check("rst_vsync",  32'(vsync_out),  32'd1);
      check("rst_pixel",  32'(pixel),      32'(k == 3));
    end
    hsync_in = 1;

    // cell (2,1): char 0x35 -> font 0x29 -> row 0xA0
    pat = 8'hA0;
    for (int i = 0; i < 11; i++) begin
      if (i < 8) begin hpos = 10'(16 + i); active_in = 1; end
      else begin hpos = 10'd700; active_in = 0; end
      vpos = 10'd9;
      @(negedge clk);
      if (i == 0) check("lit_char_addr", 32'(char_addr), 32'd82);
      if (i == 1) check("lit_font_addr", 32'(font_addr), 32'h29);
      if (i >= 3) check("lit_pixel", 32'(pixel), 32'(pat[7 - (i - 3)]));
    end

    // sync delay: hsync low at edges N,N+1; vsync low at N+2,N+3
    for (int i = 0; i < 8; i++) begin
      hsync_in = !(i == 0 || i == 1);
      vsync_in = !(i == 2 || i == 3);
      @(negedge clk);
      check("lit_hsync_dly", 32'(hsync_out), 32'(!(i == 3 || i == 4)));
      check("lit_vsync_dly", 32'(vsync_out), 32'(!(i == 5 || i == 6)));
    end
    hsync_in = 1; vsync_in = 1;

    // cursor blink over a full counter period, starting from a cleared counter
    reset = 1;
    @(negedge clk);
    reset = 0;
    cursor_en = 1; cursor_col = 7'd0; cursor_row = 6'd0;
    for (int f = 0; f <= 32; f++) begin
      draw_cell((f % 32) >= 16);
      pulse_vsync();
    end
    for (int f = 0; f < 19; f++) pulse_vsync();
    draw_cell(1'b1);

    // reset mid-line during frame 20
    for (int i = 0; i < 4; i++) begin
      hpos = 10'(i); vpos = 10'd0; active_in = 1;
      @(negedge clk);
    end
    reset = 1;
    @(negedge clk);
    check("mid_rst_pixel",     32'(pixel),      32'd0);
    check("mid_rst_active",    32'(active_out), 32'd0);
    check("mid_rst_hsync",     32'(hsync_out),  32'd1);
    check("mid_rst_vsync",     32'(vsync_out),  32'd1);
    check("mid_rst_char_addr", 32'(char_addr),  32'd0);
    check("mid_rst_font_addr", 32'(font_addr),  32'd0);
    reset = 0;
    draw_cell(1'b0);

    // blanking over the cursor cell with a 0xFF font row
    for (int v = 1; v < 8; v++) begin
      for (int h = 0; h < 8; h++) begin
        hpos = 10'(h); vpos = 10'(v); active_in = 0;
        @(negedge clk);
        check("blank_pixel",     32'(pixel),     32'd0);
        check("blank_char_addr", 32'(char_addr), 32'd0);
      end
    end

    // out-of-range cursor coordinates
    cursor_col = 7'd100; cursor_row = 6'd0;
    for (int i = 0; i < 20; i++) begin
      hpos = 10'(800 + (i % 8)); vpos = 10'd0; active_in = 1;
      @(negedge clk);
    end

    // randomized traffic
    for (int n = 0; n < 4000; n++) begin
      int hp, vp;
      hp = $urandom_range(0, 799);
      vp = $urandom_range(0, 524);
      hpos = 10'(hp);
      vpos = 10'(vp);
      active_in = ($urandom_range(0, 7) == 0) ? 1'($urandom) : (hp < 640 && vp < 480);
      hsync_in = ($urandom_range(0, 9) != 0);
      vsync_in = ($urandom_range(0, 29) != 0);
      cursor_en = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) == 1) begin
        cursor_col = 7'(hp / 8);
        cursor_row = 6'(vp / 8);
      end else begin
        cursor_col = 7'($urandom_range(0, 127));
        cursor_row = 6'($urandom_range(0, 63));
      end
      reset = ($urandom_range(0, 499) == 0);
      @(negedge clk);
    end
    reset = 0;
    repeat (4) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
